// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the memory-stage responder.
package dbus_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // An access is aligned when the low address bits below 2^size are all zero.
  function automatic logic is_misaligned(input logic [2:0] lo, input msize_t size);
    logic [3:0] span;
    logic [2:0] mask;
    span = 4'd1 << size;
    mask = 3'(span - 4'd1);
    return (lo & mask) != 3'd0;
  endfunction

endpackage

// File: rtl/dbus_ram.sv
// DEPTH x 64 word store with per-byte write enables, synchronous write,
// asynchronous read. Contents are never cleared by reset.
module dbus_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  // Byte-lane write; unselected lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus slave: accepts one request, waits LATENCY cycles,
// then issues a single-cycle response and commits any write.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          mis_q, mis_d;
  logic [7:0]    strb_q, strb_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata;
  logic          we;

  // Address bits above the word index are intentionally dropped (wrap).
  logic unused_hi;
  assign unused_hi = ^dreq.addr[63:AW+3];

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      strb_q  <= 8'h0;
      wdata_q <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: latch on accept, count down, then one response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          idx_d   = dreq.addr[3 +: AW];
          mis_d   = is_misaligned(dreq.addr[2:0], dreq.size);
          strb_d  = dreq.strobe;
          wdata_d = dreq.data;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: response only in RESP with the initiator still waiting; the
  // write commits in RESP even if abandoned, but never under reset.
  always_comb begin
    dresp    = '0;
    misalign = 1'b0;
    we       = 1'b0;
    if (state_q == RESP && !reset) begin
      we = !mis_q && (strb_q != 8'h0);
      if (dreq.valid) begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = mis_q ? 64'h0 : rdata;
        misalign      = mis_q;
      end
    end
  end

  dbus_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .be_i    (strb_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

endmodule
